// File: rtl/pool_row_shifter.sv
// Row delay line with optional pairwise row-max pooling.
// Define POOL_ROW_MAX_EN to build the pool_out/pool_valid comparator path.
module pool_row_shifter #(
  parameter int DATA_W    = 8,
  parameter int MAX_DEPTH = 16,
  parameter int DEPTH_W   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DEPTH_W-1:0] delay,
  input  logic [DATA_W-1:0]  in,
  input  logic               CE,
  output logic [DATA_W-1:0]  out,
  output logic               out_valid,
  output logic [DATA_W-1:0]  pool_out,
  output logic               pool_valid
);

  localparam int PTR_W =
    (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
  localparam int SUM_W = DEPTH_W + 1;
  localparam logic [SUM_W-1:0] C_MAX =
    SUM_W'(MAX_DEPTH);
  localparam logic [PTR_W-1:0] C_LAST =
    PTR_W'(MAX_DEPTH - 1);

  logic [DATA_W-1:0]  r_mem [MAX_DEPTH];
  logic [PTR_W-1:0]   r_wptr;
  logic [DEPTH_W-1:0] r_dq;
  logic [DEPTH_W-1:0] r_cnt;
  logic [DATA_W-1:0]  r_out;
  logic               r_out_valid;

  logic               w_accept;
  logic [DEPTH_W-1:0] w_dclamp;
  logic [SUM_W-1:0]   w_sum;
  logic [PTR_W-1:0]   w_rd_ptr;
  logic [PTR_W-1:0]   w_wptr_nx;
  logic               w_fill_hit;
  logic               w_vld_nx;
  logic [DATA_W-1:0]  w_dly_raw;
  logic [DATA_W-1:0]  w_dly;

  assign w_accept = CE;

  assign w_dclamp = ({1'b0, delay} > C_MAX)
                  ? C_MAX[DEPTH_W-1:0]
                  : delay;

  // Read slot is wptr - D_q modulo MAX_DEPTH.
  // D_q == MAX_DEPTH lands on wptr itself,
  // whose old contents are read before the write.
  assign w_sum = SUM_W'(r_wptr) + C_MAX
               - SUM_W'(r_dq);
  assign w_rd_ptr = PTR_W'((w_sum >= C_MAX)
                  ? (w_sum - C_MAX) : w_sum);

  assign w_wptr_nx = (r_wptr == C_LAST)
                   ? '0 : (r_wptr + 1'b1);

  assign w_fill_hit = (r_cnt == r_dq);
  assign w_vld_nx   = r_out_valid | w_fill_hit;

  assign w_dly_raw = (r_dq == '0)
                   ? in : r_mem[w_rd_ptr];
  // Stale buffer slots never reach the outputs.
  assign w_dly = w_vld_nx ? w_dly_raw : '0;

  always_ff @(posedge clk) begin
    if (rst && w_accept) begin
      r_mem[r_wptr] <= in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr      <= '0;
      r_cnt       <= '0;
      r_dq        <= w_dclamp;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_wptr      <= w_wptr_nx;
      r_out       <= w_dly;
      r_out_valid <= w_vld_nx;
      if (!w_fill_hit) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;

`ifdef POOL_ROW_MAX_EN
  logic [DATA_W-1:0] r_pool;
  logic              r_pool_vld;
  logic [DATA_W-1:0] w_max;

  assign w_max = (in > w_dly) ? in : w_dly;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pool     <= '0;
      r_pool_vld <= 1'b0;
    end else if (w_accept) begin
      r_pool     <= w_max;
      r_pool_vld <= w_vld_nx;
    end
  end

  assign pool_out   = r_pool;
  assign pool_valid = r_pool_vld;
`else
  assign pool_out   = '0;
  assign pool_valid = 1'b0;
`endif

endmodule

// File: tb/tb_pool_row_shifter.sv
// Directed bench for pool_row_shifter.
// Pool expectations follow POOL_ROW_MAX_EN.
module tb_pool_row_shifter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] delay = '0;
  logic [7:0] in = '0;
  logic       CE = 1'b0;
  logic [7:0] out;
  logic       out_valid;
  logic [7:0] pool_out;
  logic       pool_valid;

  int checks = 0;
  int errors = 0;

  pool_row_shifter #(
    .DATA_W(8),
    .MAX_DEPTH(16),
    .DEPTH_W(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .delay(delay),
    .in(in),
    .CE(CE),
    .out(out),
    .out_valid(out_valid),
    .pool_out(pool_out),
    .pool_valid(pool_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag,
                         input int eo,
                         input bit ev,
                         input int ep,
                         input bit epv);
    chk({tag, ".out"}, 32'(out), 32'(eo));
    chk({tag, ".vld"}, 32'(out_valid), 32'(ev));
`ifdef POOL_ROW_MAX_EN
    chk({tag, ".pool"}, 32'(pool_out), 32'(ep));
    chk({tag, ".pvld"}, 32'(pool_valid), 32'(epv));
`else
    chk({tag, ".pool"}, 32'(pool_out), 32'd0);
    chk({tag, ".pvld"}, 32'(pool_valid), 32'd0);
`endif
  endtask

  task automatic step(input bit ce,
                      input logic [7:0] d);
    CE = ce;
    in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_rst(input logic [4:0] d);
    rst   = 1'b0;
    CE    = 1'b1;
    delay = d;
    @(posedge clk);
    #1;
    rst = 1'b1;
    CE  = 1'b0;
  endtask

  initial begin
    int ep;

    // delay 2, continuous stream
    do_rst(5'd2);
    chk_all("rst", 0, 0, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      step(1'b1, 8'(k));
      chk_all($sformatf("d2.k%0d", k),
              (k >= 3) ? k - 2 : 0, k >= 3,
              k, k >= 3);
    end

    // mid-stream reset, delay edits ignored after
    do_rst(5'd2);
    for (int k = 1; k <= 4; k++) step(1'b1, 8'(k));
    chk_all("pre_rst", 2, 1, 4, 1);
    rst = 1'b0;
    CE  = 1'b1;
    in  = 8'd99;
    @(posedge clk);
    #1;
    chk_all("mid_rst", 0, 0, 0, 0);
    rst   = 1'b1;
    delay = 5'd0;
    step(1'b1, 8'd10);
    chk_all("refill1", 0, 0, 10, 0);
    step(1'b1, 8'd20);
    chk_all("refill2", 0, 0, 20, 0);
    step(1'b1, 8'd30);
    chk_all("refill3", 10, 1, 30, 1);

    // delay 0, then hold with CE low
    do_rst(5'd0);
    step(1'b1, 8'd5);
    chk_all("d0", 5, 1, 5, 1);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 8'd7);
      chk_all($sformatf("hold%0d", k), 5, 1, 5, 1);
    end

    // delay 8, CE on even samples only
    do_rst(5'd8);
    ep = 0;
    for (int i = 1; i <= 16; i++) begin
      step(i % 2 == 0, 8'(i));
      if (i % 2 == 0) ep = i;
      chk_all($sformatf("d8.i%0d", i), 0, 0, ep, 0);
    end

    // delay 20 clamps to 16, wraps twice
    do_rst(5'd20);
    for (int k = 1; k <= 40; k++) begin
      step(1'b1, 8'(k + 100));
      chk_all($sformatf("d16.k%0d", k),
              (k >= 17) ? k - 16 + 100 : 0,
              k >= 17, k + 100, k >= 17);
    end

    // pooling pattern
    do_rst(5'd1);
    step(1'b1, 8'd3);
    chk_all("pool1", 0, 0, 3, 0);
    step(1'b1, 8'd9);
    chk_all("pool2", 3, 1, 9, 1);
    step(1'b1, 8'd4);
    chk_all("pool3", 9, 1, 9, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
